// File: rtl/wash_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// wash_cycle_sequencer
//
// Cycle controller for the washing machine. Runs a per-mode recipe of water
// phases (SOAK / WASH / RINSE), each bracketed by FILL and DRAIN, times every
// phase, drives the valve / motor / door-lock actuators and handles pause,
// door interlock and fill/drain timeout faults.
//
// Optional feature macro: DRY_SPIN_EN
//   defined   : after the final DRAIN a SPIN phase of SPIN_TICKS cycles runs
//               (drain_valve, motor_on, motor_fast all 1), then DONE.
//   undefined : the final DRAIN goes straight to DONE; motor_fast_o stays 0.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   start_i        start request, sampled only in IDLE / DONE
//   pause_i        1 = hold the running cycle
//   door_closed_i  door sensor, 1 = closed
//   mode_i[1:0]    00 full, 01 quick, 10 rinse-only, 11 soak+rinse
//   level_full_i   tank-full sensor
//   level_empty_i  tank-empty sensor
//   door_lock_o    1 in every active state (FILL..SPIN, PAUSE)
//   fill_valve_o   1 only in FILL
//   drain_valve_o  1 in DRAIN and SPIN
//   motor_on_o     1 in SOAK, WASH, RINSE, SPIN
//   motor_fast_o   1 only in SPIN
//   phase_o[3:0]   current state code (IDLE=0 .. FAULT=9), doubles as FSM debug
//   busy_o         1 when not IDLE, DONE or FAULT
//   done_o         one-cycle pulse on entry to DONE
//   fault_o        1 while in FAULT
//
// All outputs are registers decoded from the next state, so they always match
// phase_o and there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module wash_cycle_sequencer #(
    parameter int SOAK_TICKS  = 16,
    parameter int WASH_TICKS  = 32,
    parameter int RINSE_TICKS = 16,
    parameter int SPIN_TICKS  = 24,
    parameter int FILL_TMO    = 64,
    parameter int DRAIN_TMO   = 64,
    parameter int TW          = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       door_closed_i,
    input  logic [1:0] mode_i,
    input  logic       level_full_i,
    input  logic       level_empty_i,
    output logic       door_lock_o,
    output logic       fill_valve_o,
    output logic       drain_valve_o,
    output logic       motor_on_o,
    output logic       motor_fast_o,
    output logic [3:0] phase_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fault_o
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FILL  = 4'd1,
        S_SOAK  = 4'd2,
        S_WASH  = 4'd3,
        S_RINSE = 4'd4,
        S_DRAIN = 4'd5,
        S_SPIN  = 4'd6,
        S_DONE  = 4'd7,
        S_PAUSE = 4'd8,
        S_FAULT = 4'd9
    } state_t;

`ifdef DRY_SPIN_EN
    localparam bit SPIN_EN = 1'b1;
`else
    localparam bit SPIN_EN = 1'b0;
`endif

    // Timer reload values: a phase of N cycles loads N-1 and leaves when 0 is read.
    localparam logic [TW-1:0] SOAK_LD  = TW'(SOAK_TICKS - 1);
    localparam logic [TW-1:0] WASH_LD  = TW'(WASH_TICKS - 1);
    localparam logic [TW-1:0] RINSE_LD = TW'(RINSE_TICKS - 1);
    localparam logic [TW-1:0] SPIN_LD  = TW'(SPIN_TICKS - 1);
    localparam logic [TW-1:0] FILL_LD  = TW'(FILL_TMO - 1);
    localparam logic [TW-1:0] DRAIN_LD = TW'(DRAIN_TMO - 1);

    state_t        state_q, state_d;
    state_t        saved_q, saved_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    step_q,  step_d;
    logic [1:0]    mode_q,  mode_d;
    logic          active_q;
    logic          active_d;

    // Water phase for a given recipe step.
    function automatic state_t step_phase(input logic [1:0] md, input logic [1:0] st);
        case (md)
            2'b00, 2'b01: step_phase = (st == 2'd0) ? S_SOAK :
                                       (st == 2'd1) ? S_WASH : S_RINSE;
            2'b10:        step_phase = S_RINSE;
            default:      step_phase = (st == 2'd0) ? S_SOAK : S_RINSE;
        endcase
    endfunction

    // Index of the final step in each recipe.
    function automatic logic [1:0] last_step(input logic [1:0] md);
        case (md)
            2'b00:   last_step = 2'd3;
            2'b01:   last_step = 2'd2;
            2'b10:   last_step = 2'd0;
            default: last_step = 2'd1;
        endcase
    endfunction

    function automatic logic [TW-1:0] water_load(input state_t ph);
        case (ph)
            S_SOAK:  water_load = SOAK_LD;
            S_WASH:  water_load = WASH_LD;
            default: water_load = RINSE_LD;
        endcase
    endfunction

    // PAUSE counts as active so the door interlock still applies while paused.
    assign active_q = (state_q inside {S_FILL, S_SOAK, S_WASH, S_RINSE,
                                       S_DRAIN, S_SPIN, S_PAUSE});
    assign active_d = (state_d inside {S_FILL, S_SOAK, S_WASH, S_RINSE,
                                       S_DRAIN, S_SPIN, S_PAUSE});

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        timer_d = timer_q;
        step_d  = step_q;
        mode_d  = mode_q;

        // Priority: door interlock, then pause, then the state's own rules.
        // A state that hands over to PAUSE leaves its timer untouched.
        if (active_q && !door_closed_i) begin
            state_d = S_FAULT;
        end else if (active_q && state_q != S_PAUSE && pause_i) begin
            saved_d = state_q;
            state_d = S_PAUSE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i && door_closed_i && !pause_i) begin
                        mode_d  = mode_i;
                        step_d  = 2'd0;
                        timer_d = FILL_LD;
                        state_d = S_FILL;
                    end
                end
                S_FILL: begin
                    if (level_full_i) begin
                        state_d = step_phase(mode_q, step_q);
                        timer_d = water_load(step_phase(mode_q, step_q));
                    end else if (timer_q == '0) begin
                        state_d = S_FAULT;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                S_SOAK, S_WASH, S_RINSE: begin
                    if (timer_q == '0) begin
                        state_d = S_DRAIN;
                        timer_d = DRAIN_LD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (level_empty_i) begin
                        if (step_q == last_step(mode_q)) begin
                            if (SPIN_EN) begin
                                state_d = S_SPIN;
                                timer_d = SPIN_LD;
                            end else begin
                                state_d = S_DONE;
                            end
                        end else begin
                            step_d  = step_q + 2'd1;
                            state_d = S_FILL;
                            timer_d = FILL_LD;
                        end
                    end else if (timer_q == '0) begin
                        state_d = S_FAULT;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                S_SPIN: begin
                    if (timer_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (!pause_i) begin
                        state_d = saved_q;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            saved_q       <= S_IDLE;
            timer_q       <= '0;
            step_q        <= 2'd0;
            mode_q        <= 2'd0;
            door_lock_o   <= 1'b0;
            fill_valve_o  <= 1'b0;
            drain_valve_o <= 1'b0;
            motor_on_o    <= 1'b0;
            motor_fast_o  <= 1'b0;
            phase_o       <= 4'd0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            fault_o       <= 1'b0;
        end else begin
            state_q       <= state_d;
            saved_q       <= saved_d;
            timer_q       <= timer_d;
            step_q        <= step_d;
            mode_q        <= mode_d;
            door_lock_o   <= active_d;
            fill_valve_o  <= (state_d == S_FILL);
            drain_valve_o <= (state_d == S_DRAIN) || (state_d == S_SPIN);
            motor_on_o    <= (state_d inside {S_SOAK, S_WASH, S_RINSE, S_SPIN});
            motor_fast_o  <= SPIN_EN && (state_d == S_SPIN);
            phase_o       <= state_d;
            busy_o        <= active_d;
            done_o        <= (state_d == S_DONE) && (state_q != S_DONE);
            fault_o       <= (state_d == S_FAULT);
        end
    end

endmodule
